// File: rtl/data_sync_tx_arbiter.sv
// Round-robin source-side scheduler for one enable-pulse bus synchronizer channel.
// A granted word is launched with a one-cycle enable, then held for HOLD_CYCLES cycles.
module data_sync_tx_arbiter #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_REQ     = 2,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [BUS_WIDTH-1:0]         tx_bus,
    output logic                         tx_enable,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDW-1:0]       rr_ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [BUS_WIDTH-1:0] tx_bus_q;
    logic                 tx_enable_q;
    logic [IDW-1:0]       grant_id_q;

    logic                 found;
    logic [IDW-1:0]       gnt_idx;
    logic [IDW-1:0]       rr_ptr_d;
    int                   idx;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        found     = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        req_ready = '0;
        if (state_q == IDLE && !RST) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found   = 1'b1;
                    gnt_idx = idx[IDW-1:0];
                end
            end
            if (found) req_ready[gnt_idx] = 1'b1;
        end
    end

    assign rr_ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            tx_bus_q    <= '0;
            tx_enable_q <= 1'b0;
            grant_id_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        tx_bus_q    <= req_data[gnt_idx*BUS_WIDTH +: BUS_WIDTH];
                        tx_enable_q <= 1'b1;
                        grant_id_q  <= gnt_idx;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= PULSE;
                    end
                end
                PULSE: begin
                    tx_enable_q <= 1'b0;
                    cnt_q       <= CW'(HOLD_CYCLES - 1);
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (cnt_q == '0) state_q <= IDLE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_bus    = tx_bus_q;
    assign tx_enable = tx_enable_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Directed bench for data_sync_tx_arbiter with NUM_REQ=3, HOLD_CYCLES=3.
module tb_data_sync_tx_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  req_ready;
    logic [7:0]  tx_bus;
    logic        tx_enable;
    logic [1:0]  grant_id;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    data_sync_tx_arbiter #(
        .BUS_WIDTH  (8),
        .NUM_REQ    (3),
        .HOLD_CYCLES(3)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx_bus   (tx_bus),
        .tx_enable(tx_enable),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs just after the edge, then settle before sampling.
    task automatic cyc(input logic rst, input logic [2:0] v, input logic [23:0] d);
        @(posedge CLK);
        #1;
        RST       = rst;
        req_valid = v;
        req_data  = d;
        #2;
    endtask

    initial begin
        logic [1:0] g;

        // Reset with random inputs
        cyc(1'b1, 3'($urandom), 24'($urandom));
        cyc(1'b1, 3'($urandom), 24'($urandom));
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_txbus", 32'(tx_bus), 32'h0);
        chk("rst_txen",  32'(tx_enable), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);

        // Single requester 0
        cyc(1'b0, 3'b001, 24'h0000A5);
        chk("t2_ready_c0", 32'(req_ready), 32'h1);
        chk("t2_busy_c0",  32'(busy), 32'h0);
        cyc(1'b0, 3'b000, 24'h0000A5);
        chk("t2_txen_c1",  32'(tx_enable), 32'h1);
        chk("t2_txbus_c1", 32'(tx_bus), 32'hA5);
        chk("t2_busy_c1",  32'(busy), 32'h1);
        chk("t2_grant_c1", 32'(grant_id), 32'h0);
        for (int i = 2; i <= 4; i++) begin
            cyc(1'b0, 3'b000, 24'h0000A5);
            chk("t2_txen_hold",  32'(tx_enable), 32'h0);
            chk("t2_txbus_hold", 32'(tx_bus), 32'hA5);
            chk("t2_busy_hold",  32'(busy), 32'h1);
        end
        cyc(1'b0, 3'b000, 24'h0000A5);
        chk("t2_busy_c5",  32'(busy), 32'h0);
        chk("t2_txbus_c5", 32'(tx_bus), 32'hA5);
        chk("t2_txen_c5",  32'(tx_enable), 32'h0);

        // All three valid continuously, starting from rr_ptr=0
        cyc(1'b1, 3'b000, 24'h332211);
        for (int c = 0; c <= 20; c++) begin
            cyc(1'b0, 3'b111, 24'h332211);
            g = 2'((c / 5) % 3);
            chk("t3_ready", 32'(req_ready), (c % 5 == 0) ? (32'h1 << g) : 32'h0);
            chk("t3_txen",  32'(tx_enable), (c % 5 == 1) ? 32'h1 : 32'h0);
            chk("t3_busy",  32'(busy), (c % 5 != 0) ? 32'h1 : 32'h0);
            if (c % 5 == 1) begin
                chk("t3_grant", 32'(grant_id), 32'(g));
                chk("t3_txbus", 32'(tx_bus), 32'h11 * (32'(g) + 1));
            end
        end
        cyc(1'b0, 3'b000, 24'h332211);
        chk("t3_txen_c21",  32'(tx_enable), 32'h1);
        chk("t3_grant_c21", 32'(grant_id), 32'h1);
        chk("t3_txbus_c21", 32'(tx_bus), 32'h22);
        for (int i = 22; i <= 25; i++) cyc(1'b0, 3'b000, 24'h332211);
        chk("t3_busy_c25", 32'(busy), 32'h0);

        // Lone requester 2, back-to-back words
        cyc(1'b0, 3'b100, 24'h3C0000);
        chk("t4_ready_c0", 32'(req_ready), 32'h4);
        cyc(1'b0, 3'b100, 24'hC30000);
        chk("t4_txen_c1",  32'(tx_enable), 32'h1);
        chk("t4_txbus_c1", 32'(tx_bus), 32'h3C);
        chk("t4_grant_c1", 32'(grant_id), 32'h2);
        chk("t4_ready_c1", 32'(req_ready), 32'h0);
        for (int i = 2; i <= 4; i++) begin
            cyc(1'b0, 3'b100, 24'hC30000);
            chk("t4_ready_hold", 32'(req_ready), 32'h0);
            chk("t4_txen_hold",  32'(tx_enable), 32'h0);
        end
        cyc(1'b0, 3'b100, 24'hC30000);
        chk("t4_ready_c5", 32'(req_ready), 32'h4);
        chk("t4_txbus_c5", 32'(tx_bus), 32'h3C);
        cyc(1'b0, 3'b000, 24'hC30000);
        chk("t4_txen_c6",  32'(tx_enable), 32'h1);
        chk("t4_txbus_c6", 32'(tx_bus), 32'hC3);
        chk("t4_grant_c6", 32'(grant_id), 32'h2);
        for (int i = 7; i <= 10; i++) cyc(1'b0, 3'b000, 24'hC30000);
        chk("t4_busy_c10", 32'(busy), 32'h0);

        // rr_ptr back at 0, then reset mid-hold
        cyc(1'b0, 3'b111, 24'h33225A);
        chk("t5_ready_rr0", 32'(req_ready), 32'h1);
        cyc(1'b0, 3'b000, 24'h33225A);
        chk("t5_txbus_c1", 32'(tx_bus), 32'h5A);
        cyc(1'b0, 3'b000, 24'h33225A);
        cyc(1'b1, 3'b000, 24'h33225A);
        cyc(1'b0, 3'b111, 24'h33225A);
        chk("t5_txbus_rst", 32'(tx_bus), 32'h0);
        chk("t5_busy_rst",  32'(busy), 32'h0);
        chk("t5_txen_rst",  32'(tx_enable), 32'h0);
        chk("t5_ready_rst", 32'(req_ready), 32'h1);

        // Requester 1 only pulses valid while a req0 transfer is held
        cyc(1'b0, 3'b000, 24'h33225A);
        chk("t6_txen_c1",  32'(tx_enable), 32'h1);
        chk("t6_grant_c1", 32'(grant_id), 32'h0);
        chk("t6_txbus_c1", 32'(tx_bus), 32'h5A);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 3'b010, 24'h33225A);
            chk("t6_ready_hold", 32'(req_ready), 32'h0);
            chk("t6_txen_hold",  32'(tx_enable), 32'h0);
            chk("t6_busy_hold",  32'(busy), 32'h1);
        end
        cyc(1'b0, 3'b000, 24'h33225A);
        chk("t6_busy_idle",  32'(busy), 32'h0);
        chk("t6_ready_idle", 32'(req_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 3'b000, 24'h33225A);
            chk("t6_no_txen",  32'(tx_enable), 32'h0);
            chk("t6_grant",    32'(grant_id), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
